// File: rtl/prom_burst_reader_if.sv
// Handshake and PROM bus bundle for prom_burst_reader.
// The slave side is the burst reader itself. The master side is whatever issues
// bursts, supplies PROM data and consumes the word stream.
interface prom_burst_reader_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    // Burst request
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;

    // PROM side
    logic [AW-1:0] rom_a;
    logic          rom_cs_;
    logic [DW-1:0] rom_q;

    // Output stream and status
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] csum;

    modport slave (
        input  start, base, len, rom_q, dout_ready,
        output rom_a, rom_cs_, dout, dout_valid, busy, done, csum
    );

    modport master (
        output start, base, len, rom_q, dout_ready,
        input  rom_a, rom_cs_, dout, dout_valid, busy, done, csum
    );
endinterface

// File: rtl/prom_burst_reader.sv
// Burst reader for a 32x8 bipolar mapping PROM.
// It fetches len consecutive words starting at base. Addresses wrap at 2**AW.
// Each fetch holds chip select for WAIT+1 cycles, then samples rom_q. The
// fetched word goes out on a valid/ready stream, and a running checksum of the
// burst is kept alongside it.
module prom_burst_reader #(
    parameter int AW   = 5,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    prom_burst_reader_if.slave  bus
);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);
    localparam logic [AW:0] ONE_LEFT = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] csum_q, csum_d;
    logic          dout_valid_q, dout_valid_d;
    logic          rom_cs_q, rom_cs_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state and datapath decode. Every output is derived from the next state,
    // so each output is registered and lines up with the state it belongs to.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wcnt_d      = wcnt_q;
        dout_d      = dout_q;
        csum_d      = csum_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    csum_d = '0;
                    if (bus.len != '0) begin
                        addr_d      = bus.base;
                        remaining_d = bus.len;
                        wcnt_d      = WAIT_CNT;
                        state_d     = S_ACCESS;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    dout_d  = bus.rom_q;
                    csum_d  = csum_q + bus.rom_q;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (dout_valid_q && bus.dout_ready) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - ONE_LEFT;
                    if (remaining_q == ONE_LEFT) begin
                        state_d = S_DONE;
                    end else begin
                        wcnt_d  = WAIT_CNT;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rom_cs_d     = (state_d != S_ACCESS);
        dout_valid_d = (state_d == S_OUTPUT);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers. Reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            wcnt_q       <= '0;
            dout_q       <= '0;
            csum_q       <= '0;
            dout_valid_q <= 1'b0;
            rom_cs_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            wcnt_q       <= wcnt_d;
            dout_q       <= dout_d;
            csum_q       <= csum_d;
            dout_valid_q <= dout_valid_d;
            rom_cs_q     <= rom_cs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.rom_a      = addr_q;
    assign bus.rom_cs_    = rom_cs_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.csum       = csum_q;
endmodule

// File: tb/tb_prom_burst_reader.sv
// Self-checking bench for prom_burst_reader.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected results come from a burst-level model: the list of words a burst
// should return, their sum, the address the reader ends on, and the timing
// implied by WAIT.
module tb_prom_burst_reader;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int WAIT = 1;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;

    prom_burst_reader_if #(.AW(AW), .DW(DW)) bus ();

    prom_burst_reader #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PROM contents, read combinationally at the current address
    logic [DW-1:0] prom [DEPTH];
    assign bus.rom_q = prom[bus.rom_a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_addr = 0;   // address the reader should rest on between bursts

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // 0: i*3   1: i   2: all 0xFF   3: random
    task automatic fill_prom(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0:       prom[i] = DW'(i * 3);
                1:       prom[i] = DW'(i);
                2:       prom[i] = 8'hFF;
                default: prom[i] = DW'($urandom);
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rom_a"},      32'(bus.rom_a),   0);
        check({tag, " rom_cs_"},    32'(bus.rom_cs_), 1);
        check({tag, " dout"},       32'(bus.dout),    0);
        check({tag, " dout_valid"}, 32'(bus.dout_valid), 0);
        check({tag, " busy"},       32'(bus.busy),    0);
        check({tag, " done"},       32'(bus.done),    0);
        check({tag, " csum"},       32'(bus.csum),    0);
    endtask

    // Ready policy by mode. 0: always ready. 1: random ready.
    // 2: five-cycle stall on the second word. 3: random ready plus start pokes
    // while a word is waiting.
    task automatic run_burst(input int b, input int l, input int mode, input int exp_csum);
        int exp_q[$];
        int exp_sum;
        int cycles, got, cs_low, done_cnt, stall_cnt;
        bit finished, prev_stalled, r;
        logic [DW-1:0] prev_dout;

        exp_sum = 0;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(int'(prom[(b + i) % DEPTH]));
            exp_sum = (exp_sum + int'(prom[(b + i) % DEPTH])) % 256;
        end

        @(negedge clk);
        bus.base       = AW'(b);
        bus.len        = (AW+1)'(l);
        bus.start      = 1'b1;
        bus.dout_ready = 1'b0;

        cycles = 0; got = 0; cs_low = 0; done_cnt = 0; stall_cnt = 0;
        finished = 0; prev_stalled = 0; prev_dout = '0;

        while (!finished && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            bus.start = 1'b0;

            if (!bus.rom_cs_) begin
                cs_low++;
                check("rom_a during access", 32'(bus.rom_a), (b + got) % DEPTH);
            end

            if (bus.dout_valid) begin
                check("rom_cs_ high while word waits", 32'(bus.rom_cs_), 1);
                if (prev_stalled) check("dout held under backpressure", 32'(bus.dout), 32'(prev_dout));
                case (mode)
                    0:       r = 1'b1;
                    2: begin
                        if (got == 1 && stall_cnt < 5) begin
                            r = 1'b0;
                            stall_cnt++;
                        end else begin
                            r = 1'b1;
                        end
                    end
                    default: r = 1'($urandom_range(0, 1));
                endcase
                bus.dout_ready = r;
                if (r) begin
                    if (got < l) check("dout word", 32'(bus.dout), 32'(exp_q[got]));
                    else         check("extra word delivered", 32'(got), 32'(l));
                    got++;
                    prev_stalled = 0;
                end else begin
                    prev_stalled = 1;
                    prev_dout    = bus.dout;
                end
                if (mode == 3 && $urandom_range(0, 2) == 0) begin
                    bus.start = 1'b1;
                    bus.base  = AW'($urandom);
                    bus.len   = (AW+1)'($urandom_range(1, DEPTH));
                end
            end else begin
                prev_stalled   = 0;
                bus.dout_ready = (mode == 1 || mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (bus.done) begin
                done_cnt++;
                finished = 1;
                check("busy during done", 32'(bus.busy), 1);
                if (mode == 0) check("done latency", 32'(cycles), 32'(l * (WAIT + 2) + 1));
            end
        end
        if (!finished) check("burst timeout", 0, 1);

        if (l != 0) model_addr = (b + l) % DEPTH;

        @(negedge clk);
        bus.dout_ready = 1'b0;
        check("done pulse count", 32'(done_cnt), 1);
        check("done is one cycle", 32'(bus.done), 0);
        check("busy after burst", 32'(bus.busy), 0);
        check("word count", 32'(got), 32'(l));
        check("rom_cs_ low cycles", 32'(cs_low), 32'(l * (WAIT + 1)));
        check("csum vs model", 32'(bus.csum), 32'(exp_sum));
        if (exp_csum >= 0) check("csum vs table", 32'(bus.csum), 32'(exp_csum));
        check("final rom_a", 32'(bus.rom_a), 32'(model_addr));
        check("rom_cs_ idle", 32'(bus.rom_cs_), 1);
    endtask

    typedef struct {
        int fill;
        int base;
        int len;
        int mode;
        int exp_csum;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int guard;

        vecs[0] = '{fill: 0, base: 4,  len: 3,  mode: 0, exp_csum: 45};   // 12+15+18
        vecs[1] = '{fill: 1, base: 30, len: 4,  mode: 0, exp_csum: 62};   // 30+31+0+1
        vecs[2] = '{fill: 0, base: 4,  len: 3,  mode: 2, exp_csum: 45};   // stall on word 2
        vecs[3] = '{fill: 1, base: 7,  len: 0,  mode: 0, exp_csum: 0};    // empty burst
        vecs[4] = '{fill: 2, base: 9,  len: 32, mode: 3, exp_csum: 224};  // full wrap, 32*0xFF

        bus.start = 1'b0;
        bus.base = '0;
        bus.len = '0;
        bus.dout_ready = 1'b0;
        fill_prom(0);
        rst = 1'b1;

        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_addr = 0;

        foreach (vecs[i]) begin
            fill_prom(vecs[i].fill);
            run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].exp_csum);
        end

        // A start held through DONE is seen again in IDLE and begins a new burst.
        @(negedge clk);
        bus.len = '0;
        bus.start = 1'b1;
        @(negedge clk);
        check("held start first done", 32'(bus.done), 1);
        @(negedge clk);
        check("held start idle gap done", 32'(bus.done), 0);
        check("held start idle gap busy", 32'(bus.busy), 0);
        @(negedge clk);
        check("held start second done", 32'(bus.done), 1);
        bus.start = 1'b0;
        @(negedge clk);
        check("held start released", 32'(bus.busy), 0);

        // Reset during the access of word 3 of 8 abandons the burst.
        fill_prom(3);
        @(negedge clk);
        bus.base = '0;
        bus.len = (AW+1)'(8);
        bus.start = 1'b1;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        begin
            int seen = 0;
            while (guard < 200 && !(seen == 2 && !bus.rom_cs_)) begin
                if (bus.dout_valid) seen++;
                @(negedge clk);
                guard++;
            end
        end
        check("reach word 3 access", 32'(guard < 200), 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid-burst reset");
        repeat (3) begin
            @(negedge clk);
            check("no done under reset", 32'(bus.done), 0);
        end
        rst = 1'b0;
        bus.dout_ready = 1'b0;
        model_addr = 0;
        @(negedge clk);
        check("no done after reset", 32'(bus.done), 0);
        run_burst(0, 1, 0, -1);

        // Random bursts against the model
        for (int n = 0; n < 10; n++) begin
            fill_prom(3);
            run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), $urandom_range(0, 3), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
